// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor.
// Computes diff = a - b - borrow_in one bit per clock, LSB first, through a
// single full-subtractor cell with a registered borrow. Operands are taken
// on an in_valid edge while idle; the result is offered with out_valid and
// held until out_ready.
//
// Ports:
//   clk        - clock, all state updates on rising edge
//   reset      - asynchronous active-high reset
//   in_valid   - operands presented
//   in_ready   - block can accept operands (IDLE)
//   a, b       - minuend, subtrahend (WIDTH bits)
//   borrow_in  - borrow subtracted at bit 0
//   out_valid  - result available (DONE)
//   out_ready  - consumer accepts result
//   diff       - a - b - borrow_in modulo 2^WIDTH
//   borrow_out - final borrow (unsigned a < b + borrow_in)
//   overflow   - signed overflow of the subtraction
//   busy       - high in RUN or DONE
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               br_q;
  logic [CW-1:0]      cnt_q;
  // Partial result: the low bit of the full shift register is never needed
  // before completion, so only the upper WIDTH-1 bits are stored.
  logic [WIDTH-1:1]   res_q;
  logic [WIDTH-1:0]   diff_q;
  logic               borrow_q;
  logic               ovf_q;

  logic               a_bit, b_bit, d_bit, br_next, last_bit;
  logic [WIDTH-1:0]   res_full;

  // Full-subtractor cell and shift-in of the current difference bit.
  always_comb begin
    a_bit    = a_q[cnt_q];
    b_bit    = b_q[cnt_q];
    d_bit    = a_bit ^ b_bit ^ br_q;
    br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
    res_full = {d_bit, res_q};
    last_bit = (cnt_q == CW'(WIDTH - 1));
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_bit)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready   = (state_q == IDLE);
    out_valid  = (state_q == DONE);
    busy       = (state_q != IDLE);
    diff       = diff_q;
    borrow_out = borrow_q;
    overflow   = ovf_q;
  end

  // Datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            br_q  <= borrow_in;
            cnt_q <= '0;
          end
        end
        RUN: begin
          br_q  <= br_next;
          res_q <= res_full[WIDTH-1:1];
          cnt_q <= cnt_q + CW'(1);
          if (last_bit) begin
            // d_bit is the result MSB on the final bit.
            diff_q   <= res_full;
            borrow_q <= br_next;
            ovf_q    <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_bit != a_q[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Multi-cycle, bit-serial two's-complement subtractor. Computes diff = a - b - borrow_in one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow.
- It is the inverse-operation companion to the combinational ripple adder datapath. Area is traded for latency.
- Valid/ready handshakes on both input and output let it sit between pipeline stages in the arithmetic path.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands presented.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- borrow_in  input  1  incoming borrow, subtracted at bit 0.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  a - b - borrow_in, modulo 2^WIDTH.
- borrow_out  output  1  final borrow; 1 when unsigned a < b + borrow_in.
- overflow  output  1  signed overflow of the subtraction.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset, asynchronous and immediate regardless of state:
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - diff, borrow_out and overflow are all 0.
  - Operand registers, borrow register and bit counter are cleared.
  - An in-flight operation is discarded and produces no output.
- IDLE: in_ready=1.
  - On an edge with in_valid=1, capture a, b and borrow_in (borrow register loads borrow_in), set counter=0, go to RUN.
- RUN: in_ready=0. Each edge processes bit i=counter:
  - d_i = a_i ^ b_i ^ br.
  - br' = (~a_i & b_i) | (~(a_i ^ b_i) & br).
  - d_i shifts into the result register from the MSB side (after WIDTH shifts, bit 0 sits at the LSB); counter increments.
  - On the edge processing i=WIDTH-1, go to DONE.
  - diff, borrow_out and overflow are registered on that edge.
- DONE: out_valid=1, in_ready=0.
  - diff, borrow_out and overflow are held stable until the handshake.
  - On an edge with out_ready=1: out_valid drops and state returns to IDLE.
  - diff, borrow_out and overflow keep their last value until the next completion.
- Latency: acceptance edge T; out_valid is high after edge T+WIDTH. Minimum initiation interval is WIDTH+2 cycles (no overlap; in_ready is low throughout RUN and DONE).
- Flags:
  - borrow_out = br after bit WIDTH-1.
  - overflow = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]), using the captured operands.
- Inputs a, b and borrow_in are ignored outside the IDLE acceptance edge; changes during RUN have no effect.
- Backpressure: out_ready low in DONE holds state indefinitely with outputs unchanged.
- out_ready asserted outside DONE has no effect.
- in_valid asserted while not IDLE is not accepted. The producer must hold its operands until the handshake completes.
- Wrap-around: results are modulo 2^WIDTH; no saturation.

Test Plan (WIDTH=4):
- a=7, b=3, borrow_in=0, out_ready=1 -> out_valid exactly 4 edges after acceptance; diff=4, borrow_out=0, overflow=0; in_ready returns 1 the cycle after the handshake.
- a=3, b=7, borrow_in=0 -> diff=12, borrow_out=1, overflow=0.
- a=0, b=0, borrow_in=1 -> diff=15, borrow_out=1; also a=5, b=5, borrow_in=0 -> diff=0, borrow_out=0.
- a=8, b=1, borrow_in=0 (signed -8-1) -> diff=7, overflow=1, borrow_out=0.
  - Also a=7, b=15 (7-(-1)) -> diff=8, overflow=1.
- Backpressure and overlap: hold out_ready=0 for 5 cycles in DONE while toggling in_valid, a and b.
  - Required: out_valid stays 1, outputs unchanged, in_ready=0, no new capture.
  - Release out_ready: exactly one handshake.
- Reset mid-op: assert reset 2 cycles into RUN, asynchronously off a clock edge.
  - Required: out_valid=0, in_ready=1, diff=0 immediately.
  - After reset release, a new a=9, b=2 operation yields diff=7, borrow_out=0.
